// File: rtl/mem_responder.sv
// Single-word request/response responder driving an asynchronous SRAM with WAIT_STATES extra access cycles.
// Optional feature: define MEM_RESP_POSTED_WRITE_EN to signal write completion in the first ACCESS cycle.
module mem_responder #(
  parameter int MEM_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int WAIT_STATES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_r_en,
  input  logic                      mem_w_en,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic                      mem_rdy,
  output logic                      mem_cplt,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_dq_out,
  output logic                      sram_dq_oe,
  input  logic [DATA_WIDTH-1:0]     sram_dq_in,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n
);

`ifdef MEM_RESP_POSTED_WRITE_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  typedef struct packed {
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } req_t;

  state_t                    state_q;
  logic [3:0]                cnt_q, cnt_d;
  logic                      wr_q;
  logic                      rdy_q, cplt_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     dq_out_q;
  logic                      dq_oe_q, ce_n_q, oe_n_q, we_n_q;

  req_t req;
  logic req_vld, accept;

  // The closing edge of RECOVER also accepts, so back-to-back accesses
  // sustain one transfer per WAIT_STATES+2 cycles.
  always_comb begin
    req.wr   = mem_w_en;
    req.addr = mem_addr;
    req.data = mem_data_in;
    req_vld  = mem_r_en | mem_w_en;
    accept   = req_vld & (((state_q == IDLE) & rdy_q) | (state_q == RECOVER));
    cnt_d    = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rdy_q    <= 1'b0;
      cplt_q   <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dq_out_q <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q  <= 1'b1;
          cplt_q <= 1'b0;
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= RECOVER;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            cplt_q  <= ~(POSTED_WR & wr_q);
            if (!wr_q) rdata_q <= sram_dq_in;
          end else begin
            cnt_q  <= cnt_d;
            cplt_q <= 1'b0;
          end
        end
        RECOVER: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          cplt_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase

      // Write wins when both enables are high.
      if (accept) begin
        state_q <= ACCESS;
        cnt_q   <= WS_LOAD;
        wr_q    <= req.wr;
        rdy_q   <= 1'b0;
        cplt_q  <= POSTED_WR & req.wr;
        addr_q  <= req.addr;
        ce_n_q  <= 1'b0;
        oe_n_q  <= req.wr;
        we_n_q  <= ~req.wr;
        dq_oe_q <= req.wr;
        if (req.wr) dq_out_q <= req.data;
      end
    end
  end

  assign mem_data_out = rdata_q;
  assign mem_rdy      = rdy_q;
  assign mem_cplt     = cplt_q;
  assign sram_addr    = addr_q;
  assign sram_dq_out  = dq_out_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_STATES=2 instance on a small SRAM model
// and a WAIT_STATES=0 instance on an address-pattern SRAM for back-to-back reads.
module tb_mem_responder;

`ifdef MEM_RESP_POSTED_WRITE_EN
  localparam bit PW = 1'b1;
`else
  localparam bit PW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WAIT_STATES=2 instance
  logic [19:0] addr = '0;
  logic [15:0] din = '0;
  logic        r_en = 1'b0, w_en = 1'b0;
  logic [15:0] dout, sdq_out, sdq_in;
  logic [19:0] sa;
  logic        rdy, cplt, sdq_oe, ce_n, oe_n, we_n;

  // WAIT_STATES=0 instance
  logic [19:0] a0 = '0;
  logic [15:0] d0 = '0;
  logic        r0 = 1'b0, w0 = 1'b0;
  logic [15:0] dout0, sdq_out0, sdq_in0;
  logic [19:0] sa0;
  logic        rdy0, cplt0, sdq_oe0, ce_n0, oe_n0, we_n0;

  mem_responder #(.MEM_ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_data_in(din), .mem_r_en(r_en), .mem_w_en(w_en),
    .mem_data_out(dout), .mem_rdy(rdy), .mem_cplt(cplt), .sram_addr(sa), .sram_dq_out(sdq_out),
    .sram_dq_oe(sdq_oe), .sram_dq_in(sdq_in), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n));

  mem_responder #(.MEM_ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_addr(a0), .mem_data_in(d0), .mem_r_en(r0), .mem_w_en(w0),
    .mem_data_out(dout0), .mem_rdy(rdy0), .mem_cplt(cplt0), .sram_addr(sa0), .sram_dq_out(sdq_out0),
    .sram_dq_oe(sdq_oe0), .sram_dq_in(sdq_in0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0));

  // SRAM models
  logic [15:0] sram [0:255];
  assign sdq_in  = !oe_n  ? sram[sa[7:0]] : 16'h0;
  assign sdq_in0 = !oe_n0 ? (sa0[15:0] + 16'h1000) : 16'h0;
  always @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 256; i++) sram[i] <= '0;
    else if (!ce_n && !we_n) sram[sa[7:0]] <= sdq_out;

  logic [5:0] ctl, ctl0;
  assign ctl  = {ce_n, oe_n, we_n, sdq_oe, cplt, rdy};
  assign ctl0 = {ce_n0, oe_n0, we_n0, sdq_oe0, cplt0, rdy0};

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          go;
    bit          r, w;
    logic [19:0] a;
    logic [15:0] d;
    logic [5:0]  ctl;   // {ce_n, oe_n, we_n, dq_oe, cplt, rdy}
    logic [15:0] dout;
    bit          ca, cdq;
    string       nm;
  } vec_t;

  vec_t vecs[20];
  int   nv = 0;

  task automatic add(input bit go, input bit r, input bit w, input logic [19:0] a, input logic [15:0] d,
                     input logic [5:0] c, input logic [15:0] o, input bit ca, input bit cdq, input string nm);
    vecs[nv] = '{go, r, w, a, d, c, o, ca, cdq, nm};
    nv++;
  endtask

  // Waits (bounded) for rdy, presents a request for one edge; returns at the cycle-0 sample point.
  task automatic issue(input bit r, input bit w, input logic [19:0] a, input logic [15:0] d);
    int n = 0;
    while (rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("issue_rdy_timeout", 64'(rdy), 64'(1));
    r_en = r; w_en = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
    r_en = 1'b0; w_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, no;
    // Write 0x1234 -> 0x10
    add(1, 0, 1, 20'h10, 16'h1234, {1'b0, 1'b1, 1'b0, 1'b1, PW, 1'b0}, 16'h0, 1, 1, "wr_c0");
    add(0, 0, 1, 20'h10, 16'h1234, 6'b010100, 16'h0, 1, 1, "wr_c1");
    add(0, 0, 1, 20'h10, 16'h1234, 6'b010100, 16'h0, 1, 1, "wr_c2");
    add(0, 0, 1, 20'h10, 16'h1234, {1'b0, 1'b1, 1'b1, 1'b1, ~PW, 1'b0}, 16'h0, 1, 1, "wr_c3");
    add(0, 0, 1, 20'h10, 16'h1234, 6'b111001, 16'h0, 0, 0, "wr_c4");
    // Read 0x10
    add(1, 1, 0, 20'h10, 16'h0, 6'b001000, 16'h0, 1, 0, "rd_c0");
    add(0, 1, 0, 20'h10, 16'h0, 6'b001000, 16'h0, 1, 0, "rd_c1");
    add(0, 1, 0, 20'h10, 16'h0, 6'b001000, 16'h0, 1, 0, "rd_c2");
    add(0, 1, 0, 20'h10, 16'h0, 6'b011010, 16'h1234, 1, 0, "rd_c3");
    add(0, 1, 0, 20'h10, 16'h0, 6'b111001, 16'h1234, 0, 0, "rd_c4");
    // Both enables: write 0xBEEF -> 0x20, oe_n never low
    add(1, 1, 1, 20'h20, 16'hBEEF, {1'b0, 1'b1, 1'b0, 1'b1, PW, 1'b0}, 16'h1234, 1, 1, "both_c0");
    add(0, 1, 1, 20'h20, 16'hBEEF, 6'b010100, 16'h1234, 1, 1, "both_c1");
    add(0, 1, 1, 20'h20, 16'hBEEF, 6'b010100, 16'h1234, 1, 1, "both_c2");
    add(0, 1, 1, 20'h20, 16'hBEEF, {1'b0, 1'b1, 1'b1, 1'b1, ~PW, 1'b0}, 16'h1234, 1, 1, "both_c3");
    add(0, 1, 1, 20'h20, 16'hBEEF, 6'b111001, 16'h1234, 0, 0, "both_c4");
    // Read back 0x20
    add(1, 1, 0, 20'h20, 16'h0, 6'b001000, 16'h1234, 1, 0, "rb_c0");
    add(0, 1, 0, 20'h20, 16'h0, 6'b001000, 16'h1234, 1, 0, "rb_c1");
    add(0, 1, 0, 20'h20, 16'h0, 6'b001000, 16'h1234, 1, 0, "rb_c2");
    add(0, 1, 0, 20'h20, 16'h0, 6'b011010, 16'hBEEF, 1, 0, "rb_c3");
    add(0, 1, 0, 20'h20, 16'h0, 6'b111001, 16'hBEEF, 0, 0, "rb_c4");

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'(ctl), 64'(6'b111000));
    chk("rst_data", 64'({dout, sa, sdq_out}), 64'(0));
    chk("rst_ctl0", 64'(ctl0), 64'(6'b111000));
    chk("rst_data0", 64'({dout0, sa0, sdq_out0}), 64'(0));
    rst = 1'b1;
    #1 chk("rdy_at_release", 64'(rdy), 64'(0));
    @(negedge clk);
    chk("rdy_first_edge", 64'({rdy, rdy0}), 64'(2'b11));

    // Table of single transactions
    for (int i = 0; i < nv; i++) begin
      if (vecs[i].go) issue(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
      else @(negedge clk);
      chk(vecs[i].nm, 64'({ctl, dout}), 64'({vecs[i].ctl, vecs[i].dout}));
      if (vecs[i].ca)  chk({vecs[i].nm, "_addr"}, 64'(sa), 64'(vecs[i].a));
      if (vecs[i].cdq) chk({vecs[i].nm, "_dq"}, 64'(sdq_out), 64'(vecs[i].d));
    end

    // Read enable pulsed mid-access is ignored
    issue(1, 0, 20'h10, 16'h0);
    nc = 0; no = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin r_en = 1'b1; addr = 20'h20; end
      if (c == 2) r_en = 1'b0;
      if (cplt) nc++;
      if (!oe_n) no++;
    end
    chk("ignore_cplt_count", 64'(nc), 64'(1));
    chk("ignore_oe_cycles", 64'(no), 64'(3));
    chk("ignore_dout", 64'(dout), 64'(16'h1234));
    chk("ignore_idle", 64'(ctl), 64'(6'b111001));

    // Reset in cycle 1 of a write
    issue(0, 1, 20'h30, 16'h5555);
    @(negedge clk);
    chk("midrst_pre_we", 64'({ce_n, we_n}), 64'(2'b00));
    rst = 1'b0;
    #1 chk("midrst_ctl", 64'(ctl), 64'(6'b111000));
    nc = 0;
    repeat (3) begin @(negedge clk); if (cplt) nc++; end
    rst = 1'b1;
    #1 chk("midrst_rdy_release", 64'(rdy), 64'(0));
    @(negedge clk);
    chk("midrst_rdy_edge", 64'(ctl), 64'(6'b111001));
    repeat (4) begin @(negedge clk); if (cplt) nc++; end
    chk("midrst_no_cplt", 64'(nc), 64'(0));

    // WAIT_STATES=0 back-to-back reads
    r0 = 1'b1; a0 = 20'h40;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_cplt_c%0d", c), 64'(cplt0), 64'(c % 2 == 1));
      if (c % 2 == 1) chk($sformatf("b2b_dout_c%0d", c), 64'(dout0), 64'(16'h1040));
    end
    r0 = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
